// File: rtl/spike_synapse_if.sv
// Signal bundle between an upstream spike source and the spike_synapse block.
// fsm_state is a debug view of the synapse FSM: 0=IDLE, 1=REFRACT, 2=DECAY.
`timescale 1ns/1ps
interface spike_synapse_if;
  // No backpressure anywhere: spike_in/weight are sampled every cycle, and
  // count_valid is a one-cycle qualifier for spike_count with no ready.
  logic       spike_in;
  logic [7:0] weight;
  logic [7:0] stim_current;
  logic [7:0] spike_count;
  logic       count_valid;
  logic [1:0] fsm_state;

  modport master (
    output spike_in, weight,
    input  stim_current, spike_count, count_valid, fsm_state
  );

  modport slave (
    input  spike_in, weight,
    output stim_current, spike_count, count_valid, fsm_state
  );
endinterface

// File: rtl/spike_synapse.sv
// Spike-driven synapse: saturating current injection with refractory gating and
// shift-based decay. Optional rate counter enabled by SPIKE_SYNAPSE_RATE_COUNT_EN.
`timescale 1ns/1ps
module spike_synapse #(
  parameter int DECAY_SHIFT = 3,
  parameter int REFRACT     = 4,
  parameter int WINDOW      = 64
) (
  input logic            clk,
  input logic            rst_n,
  spike_synapse_if.slave syn
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REFRACT = 2'd1,
    S_DECAY   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       spk_q;
  logic [7:0] stim_q, stim_d;
  logic [7:0] refr_q, refr_d;
  logic       spk_edge;
  logic       accept;
  logic [8:0] sum9;
  logic [7:0] step;
  logic [7:0] decayed;

  always_comb begin
    spk_edge = syn.spike_in & ~spk_q;
    accept   = spk_edge && (state_q != S_REFRACT);
    sum9     = {1'b0, stim_q} + {1'b0, syn.weight};
    step     = stim_q >> DECAY_SHIFT;
    if (step == 8'd0) step = 8'd1;
    decayed  = (stim_q == 8'd0) ? 8'd0 : stim_q - step;
  end

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    refr_d  = refr_q;
    if (accept) begin
      // An accepting cycle adds the weight only; decay resumes next cycle.
      stim_d  = sum9[8] ? 8'hFF : sum9[7:0];
      refr_d  = 8'(REFRACT);
      state_d = S_REFRACT;
    end else begin
      case (state_q)
        S_IDLE: stim_d = 8'd0;
        S_REFRACT: begin
          stim_d = decayed;
          refr_d = refr_q - 8'd1;
          if (refr_q <= 8'd1) state_d = S_DECAY;
        end
        S_DECAY: begin
          stim_d = decayed;
          if (decayed == 8'd0) state_d = S_IDLE;
        end
        default: begin
          stim_d  = 8'd0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      spk_q   <= 1'b0;
      stim_q  <= 8'd0;
      refr_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      spk_q   <= syn.spike_in;
      stim_q  <= stim_d;
      refr_q  <= refr_d;
    end
  end

  assign syn.stim_current = stim_q;
  assign syn.fsm_state    = state_q;

`ifdef SPIKE_SYNAPSE_RATE_COUNT_EN
  localparam int WIN_W = $clog2(WINDOW);

  logic [WIN_W-1:0] win_q;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_inc;
  logic [7:0]       count_q;
  logic             valid_q;
  logic             win_last;

  always_comb begin
    cnt_inc  = (accept && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    win_last = (win_q == WIN_W'(WINDOW - 1));
  end

  // The closing cycle's own edge is folded into the reported total.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q   <= '0;
      cnt_q   <= 8'd0;
      count_q <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= win_last;
      if (win_last) begin
        win_q   <= '0;
        cnt_q   <= 8'd0;
        count_q <= cnt_inc;
      end else begin
        win_q   <= win_q + 1'b1;
        cnt_q   <= cnt_inc;
      end
    end
  end

  assign syn.spike_count = count_q;
  assign syn.count_valid = valid_q;
`else
  assign syn.spike_count = 8'd0;
  assign syn.count_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_synapse.sv
// Bench for spike_synapse: directed literal sequences plus randomized traffic
// checked every cycle against an integer model of the synapse behaviour.
`timescale 1ns/1ps
module tb_spike_synapse;
  localparam int DECAY_SHIFT = 3;
  localparam int REFRACT     = 4;
  localparam int WINDOW      = 64;
  localparam int W           = 19;
`ifdef SPIKE_SYNAPSE_RATE_COUNT_EN
  localparam bit RATE_EN = 1'b1;
`else
  localparam bit RATE_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_REFRACT = 1, M_DECAY = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spike_synapse_if syn();

  spike_synapse #(
    .DECAY_SHIFT(DECAY_SHIFT),
    .REFRACT    (REFRACT),
    .WINDOW     (WINDOW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .syn  (syn.slave)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  int since_rst = 0;

  // Behavioural model: plain integers, spike rules applied once per cycle.
  int m_stim = 0, m_mode = M_IDLE, m_since = 0, m_prev = 0;
  int m_win = 0, m_acc = 0, m_count = 0, m_valid = 0;

  function automatic int decay_of(input int v);
    int d;
    if (v == 0) return 0;
    d = v / (1 << DECAY_SHIFT);
    if (d < 1) d = 1;
    return v - d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int s, input int w, input int r);
    int accepted;
    if (r == 0) begin
      m_stim = 0; m_mode = M_IDLE; m_since = 0; m_prev = 0;
      m_win = 0; m_acc = 0; m_count = 0; m_valid = 0;
    end else begin
      accepted = (s == 1 && m_prev == 0 && m_mode != M_REFRACT) ? 1 : 0;
      m_prev = s;
      if (accepted == 1) begin
        m_stim  = (m_stim + w > 255) ? 255 : m_stim + w;
        m_mode  = M_REFRACT;
        m_since = 0;
      end else if (m_mode == M_REFRACT) begin
        m_stim = decay_of(m_stim);
        m_since++;
        if (m_since == REFRACT) m_mode = M_DECAY;
      end else if (m_mode == M_DECAY) begin
        m_stim = decay_of(m_stim);
        if (m_stim == 0) m_mode = M_IDLE;
      end else begin
        m_stim = 0;
      end
      m_acc += accepted;
      if (m_win == WINDOW - 1) begin
        m_count = (m_acc > 255) ? 255 : m_acc;
        m_valid = 1;
        m_acc   = 0;
        m_win   = 0;
      end else begin
        m_valid = 0;
        m_win++;
      end
    end
    exp_q.push_back({8'(m_stim), 2'(m_mode),
                     RATE_EN ? 8'(m_count) : 8'd0,
                     RATE_EN ? 1'(m_valid) : 1'b0});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input int s, input int w, input int r);
    syn.spike_in = 1'(s);
    syn.weight   = 8'(w);
    rst_n        = 1'(r);
    @(posedge clk);
    model_step(s, w, r);
    if (r == 0) since_rst = 0;
    else since_rst++;
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0);
    drive(0, 0, 0);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stim_current", {24'd0, syn.stim_current}, {24'd0, e[18:11]});
      check("fsm_state",    {30'd0, syn.fsm_state},    {30'd0, e[10:9]});
      check("spike_count",  {24'd0, syn.spike_count},  {24'd0, e[8:1]});
      check("count_valid",  {31'd0, syn.count_valid},  {31'd0, e[0]});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int spk_b[6]  = '{1, 0, 0, 0, 0, 1};
    int exp_b[6]  = '{200, 175, 154, 135, 119, 255};
    int exp_a[4]  = '{100, 88, 77, 68};
    int exp_c[3]  = '{50, 44, 39};
    int exp_d[6]  = '{5, 4, 3, 2, 1, 0};
    int pulses;
    int s, r, w, prev_s;

    syn.spike_in = 1'b0;
    syn.weight   = 8'd0;
    do_reset();
    check("reset_stim", {24'd0, syn.stim_current}, 0);
    check("reset_state", {30'd0, syn.fsm_state}, M_IDLE);

    // single spike decay
    drive(1, 100, 1);
    check("a_stim0", {24'd0, syn.stim_current}, exp_a[0]);
    for (int i = 1; i < 4; i++) begin
      drive(0, 100, 1);
      check($sformatf("a_stim%0d", i), {24'd0, syn.stim_current}, exp_a[i]);
    end
    for (int i = 0; i < 60 && !(syn.fsm_state == 2'd0 && syn.stim_current == 8'd0); i++)
      drive(0, 100, 1);
    check("a_end_stim", {24'd0, syn.stim_current}, 0);
    check("a_end_state", {30'd0, syn.fsm_state}, M_IDLE);

    // saturation on second edge
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(spk_b[i], 200, 1);
      check($sformatf("b_stim%0d", i), {24'd0, syn.stim_current}, exp_b[i]);
    end

    // refractory drop, then window total of one
    do_reset();
    drive(1, 50, 1);
    check("c_stim0", {24'd0, syn.stim_current}, exp_c[0]);
    drive(0, 50, 1);
    check("c_stim1", {24'd0, syn.stim_current}, exp_c[1]);
    drive(1, 50, 1);
    check("c_stim2", {24'd0, syn.stim_current}, exp_c[2]);
    check("c_state", {30'd0, syn.fsm_state}, M_REFRACT);
    while (since_rst < WINDOW) drive(0, 50, 1);
    check("c_count", {24'd0, syn.spike_count}, RATE_EN ? 1 : 0);
    check("c_valid", {31'd0, syn.count_valid}, RATE_EN ? 1 : 0);

    // small-value tail
    do_reset();
    drive(1, 5, 1);
    check("d_stim0", {24'd0, syn.stim_current}, exp_d[0]);
    for (int i = 1; i < 6; i++) begin
      drive(0, 5, 1);
      check($sformatf("d_stim%0d", i), {24'd0, syn.stim_current}, exp_d[i]);
    end
    check("d_state", {30'd0, syn.fsm_state}, M_IDLE);

    // window count with the last edge in the closing cycle
    do_reset();
    pulses = 0;
    for (int c = 0; c < WINDOW; c++) begin
      s = (c == 10 || c == 20 || c == 30 || c == 40 || c == WINDOW - 1) ? 1 : 0;
      drive(s, $urandom_range(1, 255), 1);
      if (syn.count_valid === 1'b1) pulses++;
    end
    check("e_count", {24'd0, syn.spike_count}, RATE_EN ? 5 : 0);
    check("e_valid_last", {31'd0, syn.count_valid}, RATE_EN ? 1 : 0);
    check("e_pulses", pulses, RATE_EN ? 1 : 0);

    // reset during refractory, spike held high across release
    do_reset();
    drive(1, 120, 1);
    check("f_stim_pre", {24'd0, syn.stim_current}, 120);
    check("f_state_pre", {30'd0, syn.fsm_state}, M_REFRACT);
    drive(1, 0, 0);
    check("f_rst_stim", {24'd0, syn.stim_current}, 0);
    check("f_rst_state", {30'd0, syn.fsm_state}, M_IDLE);
    check("f_rst_count", {24'd0, syn.spike_count}, 0);
    check("f_rst_valid", {31'd0, syn.count_valid}, 0);
    drive(1, 30, 1);
    check("f_rel_stim", {24'd0, syn.stim_current}, 30);
    check("f_rel_state", {30'd0, syn.fsm_state}, M_REFRACT);

    // randomized traffic
    prev_s = 1;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 399) == 0) ? 0 : 1;
      s = ($urandom_range(0, 2) == 0) ? ~prev_s & 1 : prev_s;
      w = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
      drive(s, w, r);
      prev_s = s;
    end

    drive(0, 0, 1);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_synapse.md
SPIKE_SYNAPSE -- requirements
Module: spike_synapse

Interface
REQ-001 SHALL have parameter DECAY_SHIFT, default 3, the decay divisor exponent (legal 1..7).
REQ-002 SHALL have parameter REFRACT, default 4, the cycles after an accepted spike during which new spikes are ignored (legal 1..255).
REQ-003 SHALL have parameter WINDOW, default 64, the rate-count window length in cycles (legal 2..65535).
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port spike_in, input, 1 bit: spike level from the upstream neuron.
REQ-007 SHALL have port weight, input, 8 bits: unsigned synaptic weight, sampled on an accepted edge.
REQ-008 SHALL have port stim_current, output, 8 bits: unsigned registered synaptic current driving a downstream neuron.
REQ-009 SHALL have port spike_count, output, 8 bits: accepted spikes in the last completed window.
REQ-010 SHALL have port count_valid, output, 1 bit: one-cycle pulse when spike_count updates.

Function
REQ-011 SHALL register spike_in into spk_q each cycle; an edge is spike_in=1 with spk_q=0.
REQ-012 SHALL run an FSM with states IDLE, REFRACT and DECAY.
REQ-013 SHALL accept an edge only in IDLE or DECAY; edges in REFRACT are dropped and not counted.
REQ-014 SHALL, on an accepted edge, set stim_current to min(stim_current + weight, 255), apply no decay that cycle, load the refractory counter, and enter REFRACT.
REQ-015 SHALL make an accepted edge at clock k visible on stim_current after edge k (1-cycle latency).
REQ-016 SHALL, on every non-accepting cycle in REFRACT or DECAY with stim_current != 0, subtract max(stim_current >> DECAY_SHIFT, 1) from stim_current.
REQ-017 SHALL leave REFRACT for DECAY after exactly REFRACT cycles following the accepting cycle.
REQ-018 SHALL go from DECAY to IDLE on the cycle stim_current becomes 0 with no accepted edge; an accepted edge takes priority over this transition.
REQ-019 SHALL hold stim_current at 0 in IDLE.
REQ-020 SHALL compute the weight addition at 9 bits, then saturate; stim_current SHALL never wrap.
REQ-021 SHALL run a free window counter 0..WINDOW-1 that wraps to 0.
REQ-022 SHALL count accepted edges in an 8-bit counter that saturates at 255.
REQ-023 SHALL, in the cycle the window counter equals WINDOW-1:
- load spike_count with the window total, including an edge accepted that same cycle;
- pulse count_valid for one cycle;
- clear the internal count to 0.

Reset
REQ-024 SHALL, while rst_n=0 at a clock edge, clear stim_current, spike_count, count_valid, spk_q, the refractory counter, the window counter and the internal count, and enter IDLE.
REQ-025 SHALL treat spike_in=1 on the first clock after reset release as an edge, because spk_q resets to 0.
REQ-026 SHALL abandon REFRACT, DECAY and any partial window on reset mid-operation; no partial count is reported.

Configuration
REQ-027 SHALL compile the rate counter (REQ-021..023) only when macro SPIKE_SYNAPSE_RATE_COUNT_EN is defined.
REQ-028 SHALL, without SPIKE_SYNAPSE_RATE_COUNT_EN, keep all ports, tie spike_count to 0 and count_valid to 0, and leave REQ-011..020 unchanged.

Verification
REQ-029 SHALL check a single spike: weight=100, DECAY_SHIFT=3, one edge -> stim_current 100, 88, 77, 68, ..., reaching 0, then FSM in IDLE.
REQ-030 SHALL check saturation: weight=200, REFRACT=4, edges at cycles 0 and 5 -> 200, 175, 154, 135, 119, then 255 (clamped, not 63).
REQ-031 SHALL check the refractory window: weight=50, edges at cycles 0 and 2 -> second edge ignored; stim_current 50, 44, 39; internal count 1.
REQ-032 SHALL check the small-value tail: stim_current=5, DECAY_SHIFT=3 -> 4, 3, 2, 1, 0 (minimum step 1).
REQ-033 SHALL check the window count: with the macro defined, WINDOW=64, 5 accepted edges with the last in cycle 63 -> spike_count=5 and a single count_valid pulse at cycle 63; without the macro, spike_count=0 and count_valid stays 0.
REQ-034 SHALL check reset mid-operation: rst_n=0 during REFRACT with stim_current=120 -> all outputs 0, FSM in IDLE; spike_in held high across release counts as one edge.
